// File: rtl/axi_memory_pkg.sv
// Shared definitions for the AXI4 slave memory model: burst and response
// encodings plus the read/write channel FSM state types.
package axi_memory_pkg;

  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  // Bytes moved per beat for an AXI size code.
  function automatic logic [31:0] beat_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address calculation for AXI FIXED / INCR / WRAP bursts.
// Used once per channel so read and write bursts advance independently.
module axi_burst_addr
  import axi_memory_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] step;
  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;
  logic [31:0] wrap_addr;

  // WRAP keeps the upper bits of the aligned (len+1)<<size block and lets
  // only the offset inside that block roll over.
  always_comb begin
    step      = beat_bytes(size);
    incr_addr = addr + step;
    wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    wrap_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP:  next_addr = wrap_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_memory.sv
// AXI4 slave memory model with independent read and write channel FSMs,
// one outstanding transaction per channel.
// Every word of the array starts at zero.
module axi_memory
  import axi_memory_pkg::*;
#(
  parameter int    MEM_AW    = 16,
  parameter string INIT_FILE = "main_mem.hex"
) (
  input  logic              s_aclk,
  input  logic              s_aresetn,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [31:0]       s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [31:0]       s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // ---------------- read channel ----------------
  rd_state_t         rd_state_reg, rd_state_next;
  logic [ID_W-1:0]   rd_id_reg;
  logic [31:0]       rd_addr_reg;
  logic [7:0]        rd_len_reg;
  logic [2:0]        rd_size_reg;
  logic [1:0]        rd_burst_reg;
  logic [7:0]        rd_beat_reg;
  logic [31:0]       rd_addr_next;
  logic              ar_fire, r_fire;

  axi_burst_addr u_rd_addr (
    .addr      (rd_addr_reg),
    .size      (rd_size_reg),
    .len       (rd_len_reg),
    .burst     (rd_burst_reg),
    .next_addr (rd_addr_next)
  );

  assign ar_fire = s_axi_arvalid & s_axi_arready;
  assign r_fire  = s_axi_rvalid & s_axi_rready;

  // Read FSM state register; reset aborts any burst in flight.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) rd_state_reg <= RD_IDLE;
    else            rd_state_reg <= rd_state_next;
  end

  // Read next state and R/AR outputs; data is read straight from the array
  // at the registered beat address so writes show up the cycle after commit.
  always_comb begin
    rd_state_next = rd_state_reg;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    s_axi_rid     = '0;
    s_axi_rdata   = '0;
    s_axi_rresp   = RESP_OKAY;
    case (rd_state_reg)
      RD_IDLE: begin
        s_axi_arready = s_aresetn;
        if (s_axi_arvalid && s_aresetn) rd_state_next = RD_DATA;
      end
      RD_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = (rd_beat_reg == rd_len_reg);
        s_axi_rid    = rd_id_reg;
        s_axi_rdata  = mem[rd_addr_reg[MEM_AW+1:2]];
        if (s_axi_rready && s_axi_rlast) rd_state_next = RD_IDLE;
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // Read burst context: capture AR fields, then step address/beat per R beat.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      rd_id_reg    <= '0;
      rd_addr_reg  <= '0;
      rd_len_reg   <= '0;
      rd_size_reg  <= '0;
      rd_burst_reg <= '0;
      rd_beat_reg  <= '0;
    end else if (ar_fire) begin
      rd_id_reg    <= s_axi_arid;
      rd_addr_reg  <= s_axi_araddr;
      rd_len_reg   <= s_axi_arlen;
      rd_size_reg  <= s_axi_arsize;
      rd_burst_reg <= s_axi_arburst;
      rd_beat_reg  <= '0;
    end else if (r_fire) begin
      rd_addr_reg  <= rd_addr_next;
      rd_beat_reg  <= rd_beat_reg + 8'd1;
    end
  end

  // ---------------- write channel ----------------
  wr_state_t         wr_state_reg, wr_state_next;
  logic [ID_W-1:0]   wr_id_reg;
  logic [31:0]       wr_addr_reg;
  logic [7:0]        wr_len_reg;
  logic [2:0]        wr_size_reg;
  logic [1:0]        wr_burst_reg;
  logic [7:0]        wr_beat_reg;
  logic              wr_err_reg;
  logic [31:0]       wr_addr_next;
  logic              aw_fire, w_fire, wr_last;

  axi_burst_addr u_wr_addr (
    .addr      (wr_addr_reg),
    .size      (wr_size_reg),
    .len       (wr_len_reg),
    .burst     (wr_burst_reg),
    .next_addr (wr_addr_next)
  );

  assign aw_fire = s_axi_awvalid & s_axi_awready;
  assign w_fire  = s_axi_wvalid & s_axi_wready;
  assign wr_last = (wr_beat_reg == wr_len_reg);

  // Write FSM state register; reset drops any pending burst or response.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) wr_state_reg <= WR_IDLE;
    else            wr_state_reg <= wr_state_next;
  end

  // Write next state and AW/W/B outputs. The burst length comes from AWLEN;
  // WLAST is only checked against it to flag a protocol error.
  always_comb begin
    wr_state_next = wr_state_reg;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bid     = '0;
    s_axi_bresp   = RESP_OKAY;
    case (wr_state_reg)
      WR_IDLE: begin
        s_axi_awready = s_aresetn;
        if (s_axi_awvalid && s_aresetn) wr_state_next = WR_DATA;
      end
      WR_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && wr_last) wr_state_next = WR_RESP;
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bid    = wr_id_reg;
        s_axi_bresp  = wr_err_reg ? RESP_SLVERR : RESP_OKAY;
        if (s_axi_bready) wr_state_next = WR_IDLE;
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  // Write burst context: capture AW fields, step per W beat, accumulate
  // the WLAST mismatch flag for the response.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      wr_id_reg    <= '0;
      wr_addr_reg  <= '0;
      wr_len_reg   <= '0;
      wr_size_reg  <= '0;
      wr_burst_reg <= '0;
      wr_beat_reg  <= '0;
      wr_err_reg   <= 1'b0;
    end else if (aw_fire) begin
      wr_id_reg    <= s_axi_awid;
      wr_addr_reg  <= s_axi_awaddr;
      wr_len_reg   <= s_axi_awlen;
      wr_size_reg  <= s_axi_awsize;
      wr_burst_reg <= s_axi_awburst;
      wr_beat_reg  <= '0;
      wr_err_reg   <= 1'b0;
    end else if (w_fire) begin
      wr_addr_reg  <= wr_addr_next;
      wr_beat_reg  <= wr_beat_reg + 8'd1;
      if (s_axi_wlast != wr_last) wr_err_reg <= 1'b1;
    end
  end

  // Byte-enabled array write; the array itself is never reset.
  always_ff @(posedge s_aclk) begin
    if (w_fire) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi_wstrb[i]) mem[wr_addr_reg[MEM_AW+1:2]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_memory.sv
// Directed testbench for axi_memory: bursts, wrap, byte strobes, R stalls,
// WLAST error response, overlapping channels and async reset mid-burst.
module tb_axi_memory;

  logic        s_aclk = 1'b0;
  logic        s_aresetn = 1'b0;
  logic [3:0]  s_axi_arid = '0;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = '0;
  logic [1:0]  s_axi_arburst = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [3:0]  s_axi_awid = '0;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = '0;
  logic [1:0]  s_axi_awburst = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] ebuf [16];

  axi_memory dut (
    .s_aclk        (s_aclk),
    .s_aresetn     (s_aresetn),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready)
  );

  always #5 s_aclk = ~s_aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Full write transaction: AW, W beats from wbuf/sbuf, then B.
  // bad_beat selects one beat whose WLAST is inverted (-1 for none).
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                             input logic [1:0] exp_resp);
    logic [1:0] resp;
    logic [3:0] bid;
    @(negedge s_aclk);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    for (int n = 0; n < 50 && !s_axi_awready; n++) @(negedge s_aclk);
    check("awready", s_axi_awready, 1'b1);
    @(posedge s_aclk);
    @(negedge s_aclk);
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_axi_wdata  = wbuf[b];
      s_axi_wstrb  = sbuf[b];
      s_axi_wlast  = (b == int'(len)) ^ (b == bad_beat);
      s_axi_wvalid = 1'b1;
      for (int n = 0; n < 50 && !s_axi_wready; n++) @(negedge s_aclk);
      check("wready", s_axi_wready, 1'b1);
      @(posedge s_aclk);
      @(negedge s_aclk);
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    s_axi_bready = 1'b1;
    for (int n = 0; n < 50 && !s_axi_bvalid; n++) @(negedge s_aclk);
    check("bvalid", s_axi_bvalid, 1'b1);
    resp = s_axi_bresp;
    bid  = s_axi_bid;
    check("bresp", resp, exp_resp);
    check("bid", bid, id);
    @(posedge s_aclk);
    @(negedge s_aclk);
    s_axi_bready = 1'b0;
    check("bvalid_end", s_axi_bvalid, 1'b0);
    $display("write id=%0d addr=%08h len=%0d burst=%0d bresp=%b bid=%0d", id, addr, len, burst, resp, bid);
  endtask

  // Full read transaction checked beat by beat against ebuf; with toggle set,
  // rready alternates 0/1 and stalled beats must still show the pending word.
  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int beat = 0;
    bit done = 1'b0;
    @(negedge s_aclk);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    for (int n = 0; n < 50 && !s_axi_arready; n++) @(negedge s_aclk);
    check("arready", s_axi_arready, 1'b1);
    @(posedge s_aclk);
    @(negedge s_aclk);
    s_axi_arvalid = 1'b0;
    check("rvalid_first", s_axi_rvalid, 1'b1);
    check("rid", s_axi_rid, id);
    for (int n = 0; n < 200 && !done; n++) begin
      s_axi_rready = toggle ? n[0] : 1'b1;
      if (s_axi_rvalid) begin
        check("rdata", s_axi_rdata, ebuf[beat]);
        check("rlast", s_axi_rlast, beat == int'(len));
        check("rresp", s_axi_rresp, 2'b00);
        if (s_axi_rready) begin
          if (beat == int'(len)) done = 1'b1;
          beat++;
        end
      end
      @(posedge s_aclk);
      @(negedge s_aclk);
    end
    s_axi_rready = 1'b0;
    check("rbeats", beat, int'(len) + 1);
    check("rvalid_end", s_axi_rvalid, 1'b0);
    $display("read  id=%0d addr=%08h len=%0d burst=%0d beats=%0d stall=%0d", id, addr, len, burst, beat, toggle);
  endtask

  initial begin
    // Reset: everything quiet while held.
    repeat (3) @(negedge s_aclk);
    check("rst_arready", s_axi_arready, 1'b0);
    check("rst_awready", s_axi_awready, 1'b0);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_wready", s_axi_wready, 1'b0);
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_rdata", s_axi_rdata, 32'h0);
    s_aresetn = 1'b1;
    @(negedge s_aclk);
    check("idle_arready", s_axi_arready, 1'b1);
    check("idle_awready", s_axi_awready, 1'b1);

    // INCR write 1..4 at 0x100, read back.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'(i + 1);
      sbuf[i] = 4'hF;
      ebuf[i] = 32'(i + 1);
    end
    write_burst(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, -1, 2'b00);
    read_burst(4'd3, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0);

    // WRAP read from 0x108 wraps inside the 16-byte block.
    ebuf[0] = 32'd3; ebuf[1] = 32'd4; ebuf[2] = 32'd1; ebuf[3] = 32'd2;
    read_burst(4'd7, 32'h108, 8'd3, 3'd2, 2'b10, 1'b0);

    // Partial strobe merge.
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    write_burst(4'd1, 32'h200, 8'd0, 3'd2, 2'b01, -1, 2'b00);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
    write_burst(4'd2, 32'h200, 8'd0, 3'd2, 2'b01, -1, 2'b00);
    ebuf[0] = 32'h11BB33DD;
    read_burst(4'd4, 32'h200, 8'd0, 3'd2, 2'b01, 1'b0);

    // R backpressure.
    for (int i = 0; i < 4; i++) ebuf[i] = 32'(i + 1);
    read_burst(4'd6, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1);

    // Early WLAST -> SLVERR, both beats still written.
    wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    write_burst(4'd8, 32'h300, 8'd1, 3'd2, 2'b01, 0, 2'b10);
    ebuf[0] = 32'hA0; ebuf[1] = 32'hA1;
    read_burst(4'd9, 32'h300, 8'd1, 3'd2, 2'b01, 1'b0);

    // FIXED burst: both beats land on the same word, last one wins.
    wbuf[0] = 32'd7; wbuf[1] = 32'd8;
    write_burst(4'd11, 32'h500, 8'd1, 3'd2, 2'b00, -1, 2'b00);
    ebuf[0] = 32'd8;
    read_burst(4'd13, 32'h500, 8'd0, 3'd2, 2'b01, 1'b0);

    // Overlapping read and write bursts with different IDs.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'h50 + 32'(i);
      sbuf[i] = 4'hF;
      ebuf[i] = 32'(i + 1);
    end
    fork
      write_burst(4'd9, 32'h400, 8'd3, 3'd2, 2'b01, -1, 2'b00);
      read_burst(4'd12, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0);
    join
    for (int i = 0; i < 4; i++) ebuf[i] = 32'h50 + 32'(i);
    read_burst(4'd10, 32'h400, 8'd3, 3'd2, 2'b01, 1'b0);

    // Async reset in the middle of a read burst.
    @(negedge s_aclk);
    s_axi_arid = 4'd2; s_axi_araddr = 32'h100; s_axi_arlen = 8'd3;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    @(posedge s_aclk);
    @(negedge s_aclk);
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    check("mid_rvalid", s_axi_rvalid, 1'b1);
    @(posedge s_aclk);
    @(negedge s_aclk);
    #2 s_aresetn = 1'b0;
    #1;
    check("abort_rvalid", s_axi_rvalid, 1'b0);
    check("abort_rlast", s_axi_rlast, 1'b0);
    check("abort_arready", s_axi_arready, 1'b0);
    @(negedge s_aclk);
    s_aresetn = 1'b1;
    s_axi_rready = 1'b0;
    @(negedge s_aclk);
    check("post_rvalid", s_axi_rvalid, 1'b0);
    check("post_arready", s_axi_arready, 1'b1);
    $display("reset mid-burst id=2 addr=00000100");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
